// File: rtl/vga_pkg.sv
// Shared types and helpers for the video-mode controller: timing record,
// power-on mode, total-length helpers and controller states.
package vga_pkg;

    localparam int H_W = 11;
    localparam int V_W = 10;

    typedef struct packed {
        logic [H_W-1:0] h_visible;
        logic [H_W-1:0] h_fp;
        logic [H_W-1:0] h_sync;
        logic [H_W-1:0] h_bp;
        logic           h_pol;
        logic [V_W-1:0] v_visible;
        logic [V_W-1:0] v_fp;
        logic [V_W-1:0] v_sync;
        logic [V_W-1:0] v_bp;
        logic           v_pol;
        logic [3:0]     id;
    } timing_t;

    // 1440x900, positive sync polarities.
    localparam timing_t DEFAULT_MODE = '{
        h_visible: 11'd1440, h_fp: 11'd80, h_sync: 11'd152, h_bp: 11'd232, h_pol: 1'b1,
        v_visible: 10'd900,  v_fp: 10'd1,  v_sync: 10'd3,   v_bp: 10'd28,  v_pol: 1'b1,
        id: 4'd0
    };

    // Widened by two bits so four maximal fields cannot wrap.
    function automatic logic [H_W+1:0] h_total(input timing_t t);
        return {2'b00, t.h_visible} + {2'b00, t.h_fp} + {2'b00, t.h_sync} + {2'b00, t.h_bp};
    endfunction

    function automatic logic [V_W+1:0] v_total(input timing_t t);
        return {2'b00, t.v_visible} + {2'b00, t.v_fp} + {2'b00, t.v_sync} + {2'b00, t.v_bp};
    endfunction

    typedef enum logic [1:0] {RUN, WAIT_FRAME, HOLD} state_t;

endpackage

// File: rtl/vga_mode_check.sv
// Combinational sanity check of a requested timing: non-empty visible/sync
// regions and totals that fit the generator counters.
module vga_mode_check
    import vga_pkg::*;
(
    input  timing_t cfg,
    output logic    ok,
    output logic    err
);

    logic cfg_unused;

    always_comb begin
        ok = (cfg.h_visible != '0) && (cfg.v_visible != '0) &&
             (cfg.h_sync != '0) && (cfg.v_sync != '0) &&
             (h_total(cfg) <= 13'd2048) && (v_total(cfg) <= 12'd1024);
        err = !ok;
    end

    assign cfg_unused = ^{cfg.h_pol, cfg.v_pol, cfg.id};

endmodule

// File: rtl/vga_mode_ctrl.sv
// Frame-synchronous video-mode switcher in front of a timing generator.
// Optional VGA_MODE_SETTLE_EN keeps output muted for SETTLE_FRAMES frames after a switch.
module vga_mode_ctrl
    import vga_pkg::*;
#(
    parameter int HOLD_CYCLES   = 4,
    parameter int WAIT_TIMEOUT  = 2200000,
    parameter int SETTLE_FRAMES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  timing_t        cfg,
    input  logic [H_W-1:0] h_cnt,
    input  logic [V_W-1:0] v_cnt,
    output timing_t        cur,
    output logic           timing_rst,
    output logic           mute,
    output logic           mode_done,
    output logic           cfg_err,
    output logic           cfg_timeout
);

    localparam int TMO_W  = $clog2(WAIT_TIMEOUT + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    state_t            state_reg, state_next;
    timing_t           cur_reg, cur_next, pending_reg, pending_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic ready_reg, ready_next, trst_reg, trst_next, mute_reg, mute_next;
    logic done_reg, done_next, err_reg, err_next, tmo_pulse_reg, tmo_pulse_next;
    logic cfg_ok, cfg_bad, frame_end;
`ifdef VGA_MODE_SETTLE_EN
    localparam int SET_W = $clog2(SETTLE_FRAMES + 1);
    logic             settle_reg, settle_next;
    logic [SET_W-1:0] set_cnt_reg, set_cnt_next;
`else
    if (SETTLE_FRAMES < 0) begin : g_settle_unused
    end
`endif

    vga_mode_check u_check (
        .cfg (cfg),
        .ok  (cfg_ok),
        .err (cfg_bad)
    );

    assign frame_end = ({2'b00, h_cnt} == h_total(cur_reg) - 13'd1) &&
                       ({2'b00, v_cnt} == v_total(cur_reg) - 12'd1);

    always_comb begin
        state_next     = state_reg;
        cur_next       = cur_reg;
        pending_next   = pending_reg;
        tmo_next       = tmo_reg;
        hold_next      = hold_reg;
        ready_next     = ready_reg;
        trst_next      = trst_reg;
        mute_next      = mute_reg;
        done_next      = 1'b0;
        err_next       = 1'b0;
        tmo_pulse_next = 1'b0;
`ifdef VGA_MODE_SETTLE_EN
        settle_next  = settle_reg;
        set_cnt_next = set_cnt_reg;
`endif
        case (state_reg)
            RUN: begin
`ifdef VGA_MODE_SETTLE_EN
                if (settle_reg && frame_end) begin
                    if (set_cnt_reg == SET_W'(SETTLE_FRAMES - 1)) begin
                        settle_next = 1'b0;
                        mute_next   = 1'b0;
                        done_next   = 1'b1;
                        ready_next  = 1'b1;
                    end else begin
                        set_cnt_next = set_cnt_reg + 1'b1;
                    end
                end
`endif
                if (cfg_valid && ready_reg) begin
                    if (cfg_ok) begin
                        pending_next = cfg;
                        state_next   = WAIT_FRAME;
                        ready_next   = 1'b0;
                        tmo_next     = '0;
                    end else if (cfg_bad) begin
                        err_next = 1'b1;
                    end
                end
            end
            WAIT_FRAME: begin
                tmo_next = tmo_reg + 1'b1;
                if (frame_end || tmo_reg == TMO_W'(WAIT_TIMEOUT - 1)) begin
                    tmo_pulse_next = !frame_end;
                    state_next     = HOLD;
                    cur_next       = pending_reg;
                    trst_next      = 1'b1;
                    mute_next      = 1'b1;
                    hold_next      = '0;
                end
            end
            HOLD: begin
                hold_next = hold_reg + 1'b1;
                if (hold_reg == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_next = RUN;
                    trst_next  = 1'b0;
`ifdef VGA_MODE_SETTLE_EN
                    if (SETTLE_FRAMES > 0) begin
                        settle_next  = 1'b1;
                        set_cnt_next = '0;
                    end else begin
                        mute_next  = 1'b0;
                        done_next  = 1'b1;
                        ready_next = 1'b1;
                    end
`else
                    mute_next  = 1'b0;
                    done_next  = 1'b1;
                    ready_next = 1'b1;
`endif
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            cur_reg       <= DEFAULT_MODE;
            pending_reg   <= DEFAULT_MODE;
            tmo_reg       <= '0;
            hold_reg      <= '0;
            ready_reg     <= 1'b1;
            trst_reg      <= 1'b0;
            mute_reg      <= 1'b0;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            tmo_pulse_reg <= 1'b0;
`ifdef VGA_MODE_SETTLE_EN
            settle_reg  <= 1'b0;
            set_cnt_reg <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            cur_reg       <= cur_next;
            pending_reg   <= pending_next;
            tmo_reg       <= tmo_next;
            hold_reg      <= hold_next;
            ready_reg     <= ready_next;
            trst_reg      <= trst_next;
            mute_reg      <= mute_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            tmo_pulse_reg <= tmo_pulse_next;
`ifdef VGA_MODE_SETTLE_EN
            settle_reg  <= settle_next;
            set_cnt_reg <= set_cnt_next;
`endif
        end
    end

    assign cfg_ready   = ready_reg;
    assign cur         = cur_reg;
    assign timing_rst  = trst_reg;
    assign mute        = mute_reg;
    assign mode_done   = done_reg;
    assign cfg_err     = err_reg;
    assign cfg_timeout = tmo_pulse_reg;

endmodule

// File: doc/vga_mode_ctrl.md
Name: vga_mode_ctrl

Overview:
- Runtime video-mode controller placed in front of a runtime-configurable VGA/HDMI timing generator.
- Accepts new timing configurations from a requester over a valid/ready handshake and validates them.
- Applies an accepted configuration only at a frame boundary. While switching, it holds the timing generator in reset and mutes pixel output so the sink never sees a torn frame.

Parameters:
- HOLD_CYCLES, 4: cycles timing_rst/mute stay asserted per mode switch (≥1).
- WAIT_TIMEOUT, 2200000: maximum cycles in WAIT_FRAME before a forced switch.
- SETTLE_FRAMES, 2: extra muted frames after a switch (used only with the optional feature).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  requester has a configuration
- cfg_ready  out  1  controller can accept
- cfg  in  timing_t  requested mode (h_visible/h_fp/h_sync/h_bp 11b each, h_pol; v_visible/v_fp/v_sync/v_bp 10b each, v_pol; id 4b)
- h_cnt  in  11  from timing generator
- v_cnt  in  10  from timing generator
- cur  out  timing_t  active configuration driving the generator
- timing_rst  out  1  reset to the timing generator
- mute  out  1  force blank/black on video output
- mode_done  out  1  one-cycle pulse when a new mode becomes active
- cfg_err  out  1  one-cycle pulse when a request is rejected
- cfg_timeout  out  1  one-cycle pulse when a switch is forced by timeout

Behaviour:
- Reset values:
  - state=RUN; cur=DEFAULT_MODE (1440x900: 1440/80/152/232 +pol, 900/1/3/28 +pol, id 0)
  - cfg_ready=1; timing_rst=0; mute=0; pulses=0; all counters 0.
- Totals:
  - h_total = sum of the four h fields, computed 13b; v_total = sum of the four v fields, computed 12b. No truncation.
  - frame_end = (h_cnt == cur.h_total-1) && (v_cnt == cur.v_total-1), evaluated against cur.
- Validation, on accept: reject if any of the following holds:
  - h_visible==0, v_visible==0, h_sync==0 or v_sync==0
  - h_total>2048 or v_total>1024.
- RUN:
  - cfg_ready=1.
  - On cfg_valid&&cfg_ready with a valid cfg: latch it into pending and go to WAIT_FRAME; cfg_ready=0 from the next cycle.
  - On an invalid cfg: cfg_err pulses the next cycle, the state stays RUN, and cur/pending are unchanged.
- WAIT_FRAME:
  - frame_end is sampled starting the cycle after acceptance. A frame_end coincident with acceptance is ignored.
  - On frame_end: go to HOLD.
  - A timeout counter increments each cycle. On reaching WAIT_TIMEOUT-1: go to HOLD and pulse cfg_timeout.
  - cfg_valid is ignored in this state.
- HOLD:
  - On entry, cur<=pending. timing_rst=1 and mute=1 for exactly HOLD_CYCLES cycles.
  - Then go to RUN with timing_rst=0, mute=0 and a mode_done pulse. cfg_ready=1 again on that cycle.
- Output timing: all outputs are registered. Switch latency after frame_end = 1 cycle to HOLD entry plus HOLD_CYCLES cycles.
- rst in any state: on the next cycle, reset values apply. Pending and counters are discarded, and cur returns to DEFAULT_MODE.
- Back-to-back requests: cfg_valid held high after mode_done is accepted on the first RUN cycle.

Optional Feature:
- Macro: VGA_MODE_SETTLE_EN.
- Defined:
  - After HOLD, mute stays 1 until SETTLE_FRAMES frame_end events have been counted under the new cur.
  - mode_done pulses when mute drops.
  - cfg_ready stays 0 until then.
  - rst clears the settle counter.
- Undefined: mute deasserts on HOLD exit, as in Behaviour. SETTLE_FRAMES is unused.

Decomposition:
- vga_pkg contains:
  - timing_t packed struct
  - DEFAULT_MODE constant
  - field-width localparams (H_W=11, V_W=10)
  - functions h_total()/v_total()
  - state enum {RUN, WAIT_FRAME, HOLD}
- Sub-module vga_mode_check: combinational validator, timing_t in, ok/err out. Instantiated once at the accept path.

Test Plan:
- Reset: assert rst 3 cycles → cur==DEFAULT_MODE, cfg_ready=1, timing_rst=0, mute=0, no pulses.
- Valid 640x480 request (640/16/96/48, 480/10/33/2) at h_cnt=100, v_cnt=10:
  - cfg_ready=0 next cycle.
  - At h_cnt=1903 with v_cnt=931, next cycle: timing_rst=mute=1 for 4 cycles, cur.h_visible=640.
  - After those 4 cycles: mode_done pulse, cfg_ready=1.
- Invalid requests:
  - h_visible=0 → cfg_err 1-cycle pulse; cur unchanged; cfg_ready stays 1.
  - h_total=2049 (2000/20/20/9) → cfg_err, same response as above.
- Stalled generator: valid request with h_cnt frozen at 5, WAIT_TIMEOUT=50 → cfg_timeout pulse 50 cycles after acceptance, then HOLD, then mode_done.
- rst asserted on the 2nd HOLD cycle → next cycle RUN, cur==DEFAULT_MODE, timing_rst=0, mute=0, no mode_done.
- With VGA_MODE_SETTLE_EN and SETTLE_FRAMES=2 → mute stays 1 through two 640x480 frame_ends (h_cnt=799, v_cnt=524). mode_done and cfg_ready=1 follow.
